fpu_exec_seq: RTL and testbench

Execution-side sequencer of the bfloat16 FPU: the responder to the FPU decode stage. It accepts an issued operation (`valid_execution`, `sfpu_op`, `fpu_sel`, `fpu_rnd`, operands), drives the arithmetic datapath with a start/done handshake, and returns `fpu_complete` / `fpu_result_1` to the decode stage for register-file writeback. It also guards against a hung datapath with a timeout, and accumulates sticky exception flags.

---
 rtl/fpu_exec_seq_pkg.sv | 25 ++
 rtl/fpu_exec_timeout.sv | 37 +++
 rtl/fpu_exec_seq.sv | 171 +++++++++++++++++
 tb/tb_fpu_exec_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_exec_seq_pkg.sv
// Shared definitions for the bfloat16 FPU execution sequencer:
// state encoding, canonical NaN, opcode bit positions and flag indices.
package fpu_exec_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [15:0] BF16_QNAN = 16'h7FC0;

   localparam int OP_FDIV_BIT  = 3;
   localparam int OP_FSQRT_BIT = 4;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [4:0] FLAGS_TIMEOUT = 5'b1 << FLAG_NV;

endpackage

// File: rtl/fpu_exec_timeout.sv
// WAIT-state watchdog: clearable up-counter whose terminal flag marks the
// last cycle the sequencer will wait for the datapath.
module fpu_exec_timeout #(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic rst_l,
   input  logic clr,
   input  logic en,
   output logic term
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_exec_seq.sv
// Execution-side sequencer: accepts an issued FPU op, runs the datapath via
// start/done handshake with a watchdog, and returns a one-cycle completion.
//
//   state | meaning
//   IDLE  | waiting for a legal issued FPU op
//   WAIT  | datapath running; watching done, abort and timeout
//   DONE  | completion pulse, result valid, flags merged
//   DRAIN | hold off until fpu_active drops so the same op is not reissued
module fpu_exec_seq
   import fpu_exec_seq_pkg::*;
#(
   parameter int FPLEN   = 16,
   parameter int TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             valid_execution,
   input  logic             fpu_active,
   input  logic [23:0]      sfpu_op,
   input  logic [2:0]       fpu_sel,
   input  logic [2:0]       fpu_rnd,
   input  logic [FPLEN-1:0] fs1_data,
   input  logic [FPLEN-1:0] fs2_data,
   input  logic [FPLEN-1:0] fs3_data,
   output logic             exu_start,
   output logic             exu_kill,
   output logic [23:0]      exu_op,
   output logic [2:0]       exu_rnd,
   output logic [FPLEN-1:0] exu_a,
   output logic [FPLEN-1:0] exu_b,
   output logic [FPLEN-1:0] exu_c,
   output logic             exu_iter,
   input  logic             exu_done,
   input  logic [FPLEN-1:0] exu_result,
   input  logic [4:0]       exu_flags,
   output logic             fpu_complete,
   output logic [FPLEN-1:0] fpu_result_1,
   output logic [4:0]       fflags,
   input  logic             fflags_clr,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [23:0]      op_q, op_d;
   logic [2:0]       rnd_q, rnd_d;
   logic [FPLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic             iter_q, iter_d;
   logic             start_q, start_d;
   logic             kill_q, kill_d;
   logic [FPLEN-1:0] res_q, res_d;
   logic [4:0]       flg_q, flg_d;
   logic [4:0]       fflags_q, fflags_d;

   logic issue;
   logic tmo_clr;
   logic tmo_en;
   logic tmo_term;

   fpu_exec_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk   (clk),
      .rst_l (rst_l),
      .clr   (tmo_clr),
      .en    (tmo_en),
      .term  (tmo_term)
   );

   assign issue  = valid_execution & fpu_active & (fpu_sel != 3'd0);
   assign tmo_en = (state_q == ST_WAIT);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rnd_d    = rnd_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      iter_d   = iter_q;
      start_d  = 1'b0;
      kill_d   = 1'b0;
      res_d    = res_q;
      flg_d    = flg_q;
      tmo_clr  = 1'b0;
      fflags_d = fflags_clr ? 5'b0 : fflags_q;

      unique case (state_q)
         ST_IDLE: begin
            if (issue) begin
               op_d    = sfpu_op;
               rnd_d   = fpu_rnd;
               a_d     = fs1_data;
               b_d     = fs2_data;
               c_d     = fs3_data;
               iter_d  = sfpu_op[OP_FDIV_BIT] | sfpu_op[OP_FSQRT_BIT];
               start_d = 1'b1;
               tmo_clr = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // abort outranks a coincident done; done outranks the timeout
            if (!fpu_active) begin
               kill_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (exu_done) begin
               res_d   = exu_result;
               flg_d   = exu_flags;
               state_d = ST_DONE;
            end else if (tmo_term) begin
               res_d   = FPLEN'(BF16_QNAN);
               flg_d   = FLAGS_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // a coincident clear must not swallow this op's flags
            fflags_d = fflags_clr ? flg_q : (fflags_q | flg_q);
            state_d  = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!fpu_active) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         rnd_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         iter_q   <= 1'b0;
         start_q  <= 1'b0;
         kill_q   <= 1'b0;
         res_q    <= '0;
         flg_q    <= '0;
         fflags_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rnd_q    <= rnd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         iter_q   <= iter_d;
         start_q  <= start_d;
         kill_q   <= kill_d;
         res_q    <= res_d;
         flg_q    <= flg_d;
         fflags_q <= fflags_d;
      end
   end

   assign exu_start    = start_q;
   assign exu_kill     = kill_q;
   assign exu_op       = op_q;
   assign exu_rnd      = rnd_q;
   assign exu_a        = a_q;
   assign exu_b        = b_q;
   assign exu_c        = c_q;
   assign exu_iter     = iter_q;
   assign fpu_complete = (state_q == ST_DONE);
   assign fpu_result_1 = fpu_complete ? res_q : '0;
   assign fflags       = fflags_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_exec_seq.sv
// Self-checking bench for fpu_exec_seq: directed vector table, randomized
// operations against a latency/result/flag reference model, and corner sequences.
module tb_fpu_exec_seq;

   localparam int FPLEN   = 16;
   localparam int TIMEOUT = 32;

   logic             clk = 1'b0;
   logic             rst_l;
   logic             valid_execution;
   logic             fpu_active;
   logic [23:0]      sfpu_op;
   logic [2:0]       fpu_sel;
   logic [2:0]       fpu_rnd;
   logic [FPLEN-1:0] fs1_data, fs2_data, fs3_data;
   logic             exu_start, exu_kill;
   logic [23:0]      exu_op;
   logic [2:0]       exu_rnd;
   logic [FPLEN-1:0] exu_a, exu_b, exu_c;
   logic             exu_iter;
   logic             exu_done;
   logic [FPLEN-1:0] exu_result;
   logic [4:0]       exu_flags;
   logic             fpu_complete;
   logic [FPLEN-1:0] fpu_result_1;
   logic [4:0]       fflags;
   logic             fflags_clr;
   logic             busy;

   always #5 clk = ~clk;

   fpu_exec_seq #(.FPLEN(FPLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst_l           (rst_l),
      .valid_execution (valid_execution),
      .fpu_active      (fpu_active),
      .sfpu_op         (sfpu_op),
      .fpu_sel         (fpu_sel),
      .fpu_rnd         (fpu_rnd),
      .fs1_data        (fs1_data),
      .fs2_data        (fs2_data),
      .fs3_data        (fs3_data),
      .exu_start       (exu_start),
      .exu_kill        (exu_kill),
      .exu_op          (exu_op),
      .exu_rnd         (exu_rnd),
      .exu_a           (exu_a),
      .exu_b           (exu_b),
      .exu_c           (exu_c),
      .exu_iter        (exu_iter),
      .exu_done        (exu_done),
      .exu_result      (exu_result),
      .exu_flags       (exu_flags),
      .fpu_complete    (fpu_complete),
      .fpu_result_1    (fpu_result_1),
      .fflags          (fflags),
      .fflags_clr      (fflags_clr),
      .busy            (busy)
   );

   typedef struct {
      logic [2:0]  sel;
      logic [23:0] op;
      logic [2:0]  rnd;
      logic [15:0] a, b, c;
      int          dly;   // WAIT cycle (0 = start cycle) carrying exu_done; out of range = never
      logic [15:0] res;
      logic [4:0]  flg;
      bit          clr;   // fflags_clr during the completion cycle
   } vec_t;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [4:0] fflags_m = 5'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: done on a WAIT cycle before the watchdog expires wins, else NaN + NV
   function automatic bit done_in_time(input int dly);
      return (dly >= 0) && (dly <= TIMEOUT - 1);
   endfunction

   function automatic int exp_lat(input int dly);
      return done_in_time(dly) ? dly + 1 : TIMEOUT;
   endfunction

   task automatic idle_inputs();
      valid_execution = 1'b0;
      fpu_active      = 1'b0;
      sfpu_op         = '0;
      fpu_sel         = '0;
      fpu_rnd         = '0;
      fs1_data        = '0;
      fs2_data        = '0;
      fs3_data        = '0;
      exu_done        = 1'b0;
      exu_result      = '0;
      exu_flags       = '0;
      fflags_clr      = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_start"},  32'(exu_start), 32'd0);
      chk({tag, "_kill"},   32'(exu_kill), 32'd0);
      chk({tag, "_op"},     32'(exu_op), 32'd0);
      chk({tag, "_rnd"},    32'(exu_rnd), 32'd0);
      chk({tag, "_abc"},    32'({exu_a, exu_b} | 32'(exu_c)), 32'd0);
      chk({tag, "_iter"},   32'(exu_iter), 32'd0);
      chk({tag, "_cmpl"},   32'(fpu_complete), 32'd0);
      chk({tag, "_res"},    32'(fpu_result_1), 32'd0);
      chk({tag, "_fflags"}, 32'(fflags), 32'd0);
      chk({tag, "_busy"},   32'(busy), 32'd0);
   endtask

   // entered and left at a negedge with the DUT idle
   task automatic run_op(input vec_t v);
      int cnt;
      bit got;
      logic [15:0] exp_res;
      logic [4:0]  exp_flg;
      valid_execution = 1'b1;
      fpu_active      = 1'b1;
      fpu_sel         = v.sel;
      sfpu_op         = v.op;
      fpu_rnd         = v.rnd;
      fs1_data        = v.a;
      fs2_data        = v.b;
      fs3_data        = v.c;
      @(negedge clk);
      chk("issue_busy", 32'(busy), 32'd1);
      chk("latch_op",   32'(exu_op), 32'(v.op));
      chk("latch_rnd",  32'(exu_rnd), 32'(v.rnd));
      chk("latch_ab",   {exu_a, exu_b}, {v.a, v.b});
      chk("latch_c",    32'(exu_c), 32'(v.c));
      chk("latch_iter", 32'(exu_iter), 32'(v.op[3] | v.op[4]));
      fs1_data = ~v.a;
      fs2_data = ~v.b;
      fs3_data = ~v.c;
      sfpu_op  = ~v.op;
      cnt = 0;
      got = 0;
      while (!got && cnt <= TIMEOUT + 4) begin
         if (fpu_complete) begin
            got = 1;
         end else begin
            chk("start_first_only", 32'(exu_start), 32'(cnt == 0));
            exu_done   = (cnt == v.dly);
            exu_result = (cnt == v.dly) ? v.res : 16'($urandom);
            exu_flags  = (cnt == v.dly) ? v.flg : 5'($urandom);
            @(negedge clk);
            cnt++;
         end
      end
      exp_res = done_in_time(v.dly) ? v.res : 16'h7FC0;
      exp_flg = done_in_time(v.dly) ? v.flg : 5'b10000;
      chk("complete_seen", 32'(got), 32'd1);
      chk("latency", 32'(cnt), 32'(exp_lat(v.dly)));
      chk("result", 32'(fpu_result_1), 32'(exp_res));
      fflags_m   = v.clr ? exp_flg : (fflags_m | exp_flg);
      exu_done   = 1'b0;
      fflags_clr = v.clr;
      @(negedge clk);
      fflags_clr = 1'b0;
      chk("fflags", 32'(fflags), 32'(fflags_m));
      chk("complete_one_cycle", 32'(fpu_complete), 32'd0);
      chk("result_zero", 32'(fpu_result_1), 32'd0);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("hold_a", 32'(exu_a), 32'(v.a));
      @(negedge clk);
      chk("no_reissue_busy", 32'(busy), 32'd1);
      chk("no_reissue_start", 32'(exu_start), 32'd0);
      valid_execution = 1'b0;
      fpu_active      = 1'b0;
      @(negedge clk);
      chk("back_to_idle", 32'(busy), 32'd0);
   endtask

   vec_t tbl[6];
   vec_t rv;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst_l = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_l = 1'b1;
      @(negedge clk);

      tbl[0] = '{sel: 3'b010, op: 24'h000001, rnd: 3'd0, a: 16'h3F80, b: 16'h4000, c: 16'h0000,
                 dly: 3, res: 16'h4040, flg: 5'b00000, clr: 1'b0};
      tbl[1] = '{sel: 3'b011, op: 24'h000008, rnd: 3'd1, a: 16'h4120, b: 16'h0000, c: 16'h1111,
                 dly: -1, res: 16'h0000, flg: 5'b00000, clr: 1'b0};
      tbl[2] = '{sel: 3'b001, op: 24'h000002, rnd: 3'd2, a: 16'hC000, b: 16'h3F00, c: 16'h2222,
                 dly: TIMEOUT - 1, res: 16'h3F80, flg: 5'b00000, clr: 1'b1};
      tbl[3] = '{sel: 3'b100, op: 24'h000004, rnd: 3'd3, a: 16'h0001, b: 16'h0002, c: 16'h0003,
                 dly: 0, res: 16'h5555, flg: 5'b00001, clr: 1'b0};
      tbl[4] = '{sel: 3'b101, op: 24'h800000, rnd: 3'd4, a: 16'h7F7F, b: 16'h7F7F, c: 16'h0000,
                 dly: 1, res: 16'h7F80, flg: 5'b00100, clr: 1'b1};
      tbl[5] = '{sel: 3'b111, op: 24'h000010, rnd: 3'd7, a: 16'h4080, b: 16'hFFFF, c: 16'hABCD,
                 dly: 5, res: 16'h4000, flg: 5'b00010, clr: 1'b0};
      for (int i = 0; i < 6; i++) run_op(tbl[i]);

      fflags_clr = 1'b1;
      @(negedge clk);
      fflags_clr = 1'b0;
      fflags_m   = 5'b0;
      chk("idle_clear", 32'(fflags), 32'd0);

      valid_execution = 1'b1;
      fpu_active      = 1'b1;
      fpu_sel         = 3'b000;
      @(negedge clk);
      @(negedge clk);
      chk("sel0_no_issue", 32'(busy), 32'd0);
      chk("sel0_no_start", 32'(exu_start), 32'd0);

      // abort two cycles into WAIT with a coincident done
      fpu_sel = 3'b001;
      sfpu_op = 24'h000020;
      @(negedge clk);
      valid_execution = 1'b0;
      @(negedge clk);
      @(negedge clk);
      fpu_active = 1'b0;
      exu_done   = 1'b1;
      exu_result = 16'h1234;
      exu_flags  = 5'b11111;
      @(negedge clk);
      chk("abort_kill", 32'(exu_kill), 32'd1);
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_no_cmpl", 32'(fpu_complete), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_kill_once", 32'(exu_kill), 32'd0);
         chk("late_done_ignored", 32'(fpu_complete | busy), 32'd0);
      end
      exu_done = 1'b0;
      chk("abort_fflags", 32'(fflags), 32'(fflags_m));

      for (int i = 0; i < 20; i++) begin
         rv.sel = 3'($urandom_range(1, 7));
         rv.op  = 24'($urandom);
         rv.rnd = 3'($urandom);
         rv.a   = 16'($urandom);
         rv.b   = 16'($urandom);
         rv.c   = 16'($urandom);
         rv.dly = $urandom_range(0, 40);
         rv.res = 16'($urandom);
         rv.flg = 5'($urandom);
         rv.clr = 1'($urandom_range(0, 1));
         run_op(rv);
      end

      // ensure sticky flags are non-zero before the reset check
      rv = tbl[3];
      rv.clr = 1'b0;
      run_op(rv);
      valid_execution = 1'b1;
      fpu_active      = 1'b1;
      fpu_sel         = 3'b011;
      sfpu_op         = 24'h000018;
      fs1_data        = 16'h1357;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_l      = 1'b0;
      fpu_active = 1'b0;
      @(negedge clk);
      check_all_zero("midwait_reset");
      rst_l = 1'b1;
      idle_inputs();
      @(negedge clk);
      chk("post_reset_kill", 32'(exu_kill), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
